// File: rtl/exe_muldiv_unit.sv
// Multi-cycle multiply/divide execute unit with architectural HI/LO registers.
// Optional: define MULDIV_DIV_EARLY_EXIT_EN for single-cycle trivial divides.
module exe_muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_src0,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [DATA_W-1:0] out_res,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic [1:0]          state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   out_res_reg;
    logic [TAG_W-1:0]    out_tag_reg;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   lo_reg;
    logic [DATA_W-1:0]   res_hi_reg;
    logic [DATA_W-1:0]   res_lo_reg;
    logic                wr_hi_reg;
    logic                wr_lo_reg;
    logic [2*DATA_W-1:0] prod_reg;
    logic [DATA_W:0]     rem_reg;
    logic [DATA_W-1:0]   quo_reg;
    logic [DATA_W-1:0]   dvs_reg;
    logic [DATA_W-1:0]   src0_reg;
    logic                neg_q_reg;
    logic                neg_r_reg;
    logic                div_zero_reg;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
    logic                div_early_reg;
`endif

    logic                accept;
    logic                retire;
    logic                is_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   rd_hi;
    logic [DATA_W-1:0]   rd_lo;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     diff;
    logic                q_bit;
    logic [DATA_W:0]     rem_next;
    logic [DATA_W-1:0]   quo_next;
    logic [DATA_W-1:0]   div_lo;
    logic [DATA_W-1:0]   div_hi;
    logic                unused_rem;

    assign out_valid  = (state_reg == ST_DONE);
    assign in_allowin = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_allowin);
    assign accept     = in_valid && in_allowin;
    assign retire     = out_valid && out_allowin;

    assign out_res = out_res_reg;
    assign out_tag = out_tag_reg;
    assign out_hi  = hi_reg;
    assign out_lo  = lo_reg;

    assign is_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
    assign a_neg     = is_signed && in_src0[DATA_W-1];
    assign b_neg     = is_signed && in_src1[DATA_W-1];
    assign a_mag     = a_neg ? -in_src0 : in_src0;
    assign b_mag     = b_neg ? -in_src1 : in_src1;

    // Sign/zero extension to full width makes one unsigned multiply serve both MULT and MULTU.
    assign ext_a   = {{DATA_W{a_neg}}, in_src0};
    assign ext_b   = {{DATA_W{b_neg}}, in_src1};
    assign product = ext_a * ext_b;

    // A read accepted in the same cycle the previous operation retires sees its commit.
    assign rd_hi = (retire && wr_hi_reg) ? res_hi_reg : hi_reg;
    assign rd_lo = (retire && wr_lo_reg) ? res_lo_reg : lo_reg;

    // One restoring step; the top bit of diff is the borrow.
    assign rem_shift = {rem_reg[DATA_W-1:0], quo_reg[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, dvs_reg};
    assign q_bit     = ~diff[DATA_W];
    assign rem_next  = q_bit ? diff : rem_shift;
    assign quo_next  = {quo_reg[DATA_W-2:0], q_bit};

    assign div_lo = div_zero_reg ? '1 :
                    (neg_q_reg ? -quo_next : quo_next);
    assign div_hi = div_zero_reg ? src0_reg :
                    (neg_r_reg ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0]);

    assign unused_rem = rem_reg[DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            out_res_reg  <= '0;
            out_tag_reg  <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            res_hi_reg   <= '0;
            res_lo_reg   <= '0;
            wr_hi_reg    <= 1'b0;
            wr_lo_reg    <= 1'b0;
            prod_reg     <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            src0_reg     <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
            div_early_reg <= 1'b0;
`endif
        end else if (flush_in) begin
            state_reg <= ST_IDLE;
        end else begin
            if (retire) begin
                if (wr_hi_reg) hi_reg <= res_hi_reg;
                if (wr_lo_reg) lo_reg <= res_lo_reg;
            end
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        out_tag_reg <= in_tag;
                        case (in_op)
                            OP_MULT, OP_MULTU: begin
                                prod_reg <= product;
                                if (MUL_LAT == 1) begin
                                    state_reg   <= ST_DONE;
                                    out_res_reg <= product[DATA_W-1:0];
                                    res_lo_reg  <= product[DATA_W-1:0];
                                    res_hi_reg  <= product[2*DATA_W-1:DATA_W];
                                    wr_hi_reg   <= 1'b1;
                                    wr_lo_reg   <= 1'b1;
                                end else begin
                                    state_reg <= ST_MUL;
                                    cnt_reg   <= CNT_W'(MUL_LAT - 2);
                                end
                            end
                            OP_DIV, OP_DIVU: begin
                                state_reg    <= ST_DIV;
                                cnt_reg      <= CNT_W'(DATA_W - 1);
                                rem_reg      <= '0;
                                quo_reg      <= a_mag;
                                dvs_reg      <= b_mag;
                                src0_reg     <= in_src0;
                                neg_q_reg    <= a_neg ^ b_neg;
                                neg_r_reg    <= a_neg;
                                div_zero_reg <= (in_src1 == '0);
`ifdef MULDIV_DIV_EARLY_EXIT_EN
                                div_early_reg <= (b_mag == '0) || (a_mag < b_mag);
`endif
                            end
                            OP_MFHI: begin
                                state_reg   <= ST_DONE;
                                out_res_reg <= rd_hi;
                                wr_hi_reg   <= 1'b0;
                                wr_lo_reg   <= 1'b0;
                            end
                            OP_MFLO: begin
                                state_reg   <= ST_DONE;
                                out_res_reg <= rd_lo;
                                wr_hi_reg   <= 1'b0;
                                wr_lo_reg   <= 1'b0;
                            end
                            OP_MTHI: begin
                                state_reg   <= ST_DONE;
                                out_res_reg <= in_src0;
                                res_hi_reg  <= in_src0;
                                wr_hi_reg   <= 1'b1;
                                wr_lo_reg   <= 1'b0;
                            end
                            OP_MTLO: begin
                                state_reg   <= ST_DONE;
                                out_res_reg <= in_src0;
                                res_lo_reg  <= in_src0;
                                wr_hi_reg   <= 1'b0;
                                wr_lo_reg   <= 1'b1;
                            end
                        endcase
                    end else if (retire) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cnt_reg == '0) begin
                        state_reg   <= ST_DONE;
                        out_res_reg <= prod_reg[DATA_W-1:0];
                        res_lo_reg  <= prod_reg[DATA_W-1:0];
                        res_hi_reg  <= prod_reg[2*DATA_W-1:DATA_W];
                        wr_hi_reg   <= 1'b1;
                        wr_lo_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_DIV: begin
`ifdef MULDIV_DIV_EARLY_EXIT_EN
                    if (div_early_reg) begin
                        state_reg   <= ST_DONE;
                        out_res_reg <= div_zero_reg ? '1 : '0;
                        res_lo_reg  <= div_zero_reg ? '1 : '0;
                        res_hi_reg  <= src0_reg;
                        wr_hi_reg   <= 1'b1;
                        wr_lo_reg   <= 1'b1;
                    end else
`endif
                    if (cnt_reg == '0) begin
                        // Sign fix-up folds into the final iteration's transition.
                        state_reg   <= ST_DONE;
                        out_res_reg <= div_lo;
                        res_lo_reg  <= div_lo;
                        res_hi_reg  <= div_hi;
                        wr_hi_reg   <= 1'b1;
                        wr_lo_reg   <= 1'b1;
                    end else begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit (DATA_W=32, MUL_LAT=2).
module tb_exe_muldiv_unit;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam int DIV_LAT = 33;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_in;
    logic              in_valid;
    logic              in_allowin;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_src0;
    logic [DATA_W-1:0] in_src1;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_allowin;
    logic [DATA_W-1:0] out_res;
    logic [DATA_W-1:0] out_hi;
    logic [DATA_W-1:0] out_lo;
    logic [TAG_W-1:0]  out_tag;

    int n_cmp = 0;
    int n_err = 0;

    exe_muldiv_unit #(.DATA_W(DATA_W), .MUL_LAT(2), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_allowin (in_allowin),
        .in_op      (in_op),
        .in_src0    (in_src0),
        .in_src1    (in_src1),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_allowin(out_allowin),
        .out_res    (out_res),
        .out_hi     (out_hi),
        .out_lo     (out_lo),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_allowin=1, measure latency and busy cycles, then check retirement.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int busy;
        out_allowin = 1'b1;
        check({name, "_allowin"}, 64'(in_allowin), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src0  = a;
        in_src1  = b;
        in_tag   = tg;
        tick();
        in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 200) begin
            if (!in_allowin) busy++;
            tick();
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy"}, 64'(busy), 64'(exp_lat - 1));
        check({name, "_res"}, 64'(out_res), 64'(exp_res));
        check({name, "_tag"}, 64'(out_tag), 64'(tg));
        tick();
        check({name, "_hi"}, 64'(out_hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(out_lo), 64'(exp_lo));
        $display("op %-10s tag %0d lat %0d res 0x%08h hi 0x%08h lo 0x%08h",
                 name, tg, lat, exp_res, out_hi, out_lo);
    endtask

    initial begin
        int lat;
        int seen;
        rst         = 1'b1;
        flush_in    = 1'b0;
        in_valid    = 1'b0;
        in_op       = 3'd0;
        in_src0     = '0;
        in_src1     = '0;
        in_tag      = '0;
        out_allowin = 1'b1;
        repeat (3) tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(out_res), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_hi", 64'(out_hi), 64'd0);
        check("rst_lo", 64'(out_lo), 64'd0);
        rst = 1'b0;
        check("rst_allowin", 64'(in_allowin), 64'd1);
        $display("reset released");

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 2, 32'h00000001, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'h00000002, 5'd2, DIV_LAT, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_m2",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 5'd3, DIV_LAT, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_by0",  OP_DIVU,  32'h00001234, 32'h00000000, 5'd4, EARLY_LAT, 32'hFFFFFFFF, 32'h00001234, 32'hFFFFFFFF);
        run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd5, DIV_LAT, 32'h80000000, 32'h00000000, 32'h80000000);
        run_op("divu_100_7",OP_DIVU,  32'd100,      32'd7,        5'd6, DIV_LAT, 32'h0000000E, 32'h00000002, 32'h0000000E);
        run_op("div_5_9",   OP_DIV,   32'd5,        32'd9,        5'd7, EARLY_LAT, 32'h00000000, 32'h00000005, 32'h00000000);
        run_op("div_m5_9",  OP_DIV,   32'hFFFFFFFB, 32'd9,        5'd8, EARLY_LAT, 32'h00000000, 32'hFFFFFFFB, 32'h00000000);
        run_op("mult_min2", OP_MULT,  32'h80000000, 32'd2,        5'd9, 2, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);

        // MULT 3 x -2 with the output stage stalled for five cycles.
        out_allowin = 1'b0;
        in_valid = 1'b1;
        in_op    = OP_MULT;
        in_src0  = 32'd3;
        in_src1  = 32'hFFFFFFFE;
        in_tag   = 5'd10;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("stall_lat", 64'(lat), 64'd2);
        check("stall_allowin", 64'(in_allowin), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_res", 64'(out_res), 64'hFFFFFFFA);
            check("stall_tag", 64'(out_tag), 64'd10);
            check("stall_lo_held", 64'(out_lo), 64'h00000000);
            tick();
        end
        out_allowin = 1'b1;
        tick();
        check("stall_valid_off", 64'(out_valid), 64'd0);
        check("stall_hi", 64'(out_hi), 64'hFFFFFFFF);
        check("stall_lo", 64'(out_lo), 64'hFFFFFFFA);
        $display("op mult_stall tag 10 lat %0d res 0xfffffffa hi 0x%08h lo 0x%08h", lat, out_hi, out_lo);

        // MTHI then MFHI back to back; MFHI accepted in the cycle MTHI retires.
        in_valid = 1'b1;
        in_op    = OP_MTHI;
        in_src0  = 32'hA5A5A5A5;
        in_tag   = 5'd11;
        tick();
        check("mthi_valid", 64'(out_valid), 64'd1);
        check("mthi_res", 64'(out_res), 64'hA5A5A5A5);
        check("mfhi_b2b_allowin", 64'(in_allowin), 64'd1);
        in_op   = OP_MFHI;
        in_src0 = '0;
        in_tag  = 5'd12;
        tick();
        in_valid = 1'b0;
        check("mfhi_b2b_valid", 64'(out_valid), 64'd1);
        check("mfhi_b2b_res", 64'(out_res), 64'hA5A5A5A5);
        check("mfhi_b2b_tag", 64'(out_tag), 64'd12);
        check("mthi_hi", 64'(out_hi), 64'hA5A5A5A5);
        tick();
        check("mfhi_b2b_done", 64'(out_valid), 64'd0);
        $display("op mthi/mfhi tags 11/12 res 0x%08h hi 0x%08h lo 0x%08h", 32'hA5A5A5A5, out_hi, out_lo);

        run_op("mtlo",  OP_MTLO, 32'h13579BDF, 32'd0, 5'd13, 1, 32'h13579BDF, 32'hA5A5A5A5, 32'h13579BDF);
        run_op("mflo",  OP_MFLO, 32'd0,        32'd0, 5'd14, 1, 32'h13579BDF, 32'hA5A5A5A5, 32'h13579BDF);

        // Flush in the retiring cycle must discard the commit.
        in_valid = 1'b1;
        in_op    = OP_MTLO;
        in_src0  = 32'h00000BAD;
        in_tag   = 5'd15;
        tick();
        in_valid = 1'b0;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("flush_done_valid", 64'(out_valid), 64'd0);
        check("flush_done_lo", 64'(out_lo), 64'h13579BDF);
        $display("op mtlo_flush tag 15 lo 0x%08h", out_lo);

        // DIV flushed at T+10.
        in_valid = 1'b1;
        in_op    = OP_DIV;
        in_src0  = 32'd100;
        in_src1  = 32'd7;
        in_tag   = 5'd16;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("flush_div_valid", 64'(out_valid), 64'd0);
        check("flush_div_allowin", 64'(in_allowin), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush_div_quiet", 64'(seen), 64'd0);
        $display("op div_flush tag 16 valid_seen %0d", seen);
        run_op("mfhi_post", OP_MFHI, 32'd0, 32'd0, 5'd17, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h13579BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
